axi_lite_regfile_slave: RTL and testbench

//  AXI4-Lite responder with a word-indexed register file. Accepts writes on the
//  AW/W channels, honours WSTRB byte lanes and answers on B. Serves reads on AR/R.

---
 rtl/axi_lite_regfile_if.sv | 40 ++++
 rtl/axi_lite_regfile_slave.sv | 198 +++++++++++++++++++
 tb/tb_axi_lite_regfile_slave.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regfile_if.sv
// axi_lite_regfile_if
//   AXI4-Lite bus bundle between a master and the register-file slave.
//   Carries the AW, W, B, AR and R channels; clock and reset stay outside.
//   Modports:
//     slave  - the register-file responder (drives the READY/response side)
//     master - the requester (drives addresses, data, strobes and VALIDs)
interface axi_lite_regfile_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  AWVALID;
    logic [ADDR_W-1:0]     AWADDR;
    logic                  AWREADY;
    logic                  WVALID;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  WREADY;
    logic                  BVALID;
    logic [1:0]            BRESP;
    logic                  BREADY;
    logic                  ARVALID;
    logic [ADDR_W-1:0]     ARADDR;
    logic                  ARREADY;
    logic                  RVALID;
    logic [DATA_W-1:0]     RDATA;
    logic [1:0]            RRESP;
    logic                  RREADY;

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// axi_lite_regfile_slave
//   AXI4-Lite responder in front of a word-indexed register file.
//   Writes arrive on AW/W (in either order or together), are committed lane by
//   lane under WSTRB and acknowledged on B. Reads are served on AR/R by an
//   independent FSM. Addresses are word indices; any index >= NUM_REGS
//   (including any nonzero bit above the index field) answers SLVERR.
// Ports
//   ACLK    - clock, rising edge
//   ARESET  - synchronous reset, active low
//   bus     - AXI4-Lite slave modport (AW, W, B, AR, R channels)
//   ready   - one-cycle pulse after each B handshake (write complete)
//
// state     | meaning
// ----------+---------------------------------------------------------
// WR_IDLE   | waiting for AW and/or W; both READYs high
// WR_GOT_AW | address latched, waiting for write data
// WR_GOT_W  | data/strobes latched, waiting for address
// WR_RESP   | write committed, holding BVALID/BRESP until BREADY
// RD_IDLE   | waiting for AR; ARREADY high
// RD_DATA   | holding RVALID/RDATA/RRESP until RREADY
module axi_lite_regfile_slave #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    axi_lite_regfile_if.slave    bus,
    output logic                 ready
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int LANES = DATA_W / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

    typedef enum logic [1:0] {WR_IDLE, WR_GOT_AW, WR_GOT_W, WR_RESP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [LANES-1:0]  w_strb_q;
    logic [1:0]        bresp_q;
    logic              ready_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    logic              awready, wready, bvalid;
    logic              commit;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic [LANES-1:0]  c_strb;
    logic              c_legal;
    logic              arready, rvalid;
    logic              ar_legal;

    // Write FSM: the commit happens on whichever edge completes the second
    // handshake; the mux picks live bus values for the channel completing now
    // and latched values for the channel that finished earlier.
    always_comb begin
        wr_next = wr_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        commit  = 1'b0;
        c_addr  = aw_addr_q;
        c_data  = w_data_q;
        c_strb  = w_strb_q;
        case (wr_state)
            WR_IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                if (bus.AWVALID && bus.WVALID) begin
                    wr_next = WR_RESP;
                    commit  = 1'b1;
                    c_addr  = bus.AWADDR;
                    c_data  = bus.WDATA;
                    c_strb  = bus.WSTRB;
                end else if (bus.AWVALID) begin
                    wr_next = WR_GOT_AW;
                end else if (bus.WVALID) begin
                    wr_next = WR_GOT_W;
                end
            end
            WR_GOT_AW: begin
                wready = 1'b1;
                if (bus.WVALID) begin
                    wr_next = WR_RESP;
                    commit  = 1'b1;
                    c_data  = bus.WDATA;
                    c_strb  = bus.WSTRB;
                end
            end
            WR_GOT_W: begin
                awready = 1'b1;
                if (bus.AWVALID) begin
                    wr_next = WR_RESP;
                    commit  = 1'b1;
                    c_addr  = bus.AWADDR;
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bus.BREADY) begin
                    wr_next = WR_IDLE;
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // Full-width compare so any nonzero bit above the index field is illegal.
    assign c_legal  = (c_addr < NUM_REGS_A);
    assign ar_legal = (bus.ARADDR < NUM_REGS_A);

    always_comb begin
        rd_next = rd_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                arready = 1'b1;
                if (bus.ARVALID) begin
                    rd_next = RD_DATA;
                end
            end
            RD_DATA: begin
                rvalid = 1'b1;
                if (bus.RREADY) begin
                    rd_next = RD_IDLE;
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            wr_state  <= WR_IDLE;
            rd_state  <= RD_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            ready_q  <= bvalid && bus.BREADY;

            if (awready && bus.AWVALID) begin
                aw_addr_q <= bus.AWADDR;
            end
            if (wready && bus.WVALID) begin
                w_data_q <= bus.WDATA;
                w_strb_q <= bus.WSTRB;
            end

            if (commit) begin
                bresp_q <= c_legal ? RESP_OKAY : RESP_SLVERR;
                if (c_legal) begin
                    for (int b = 0; b < LANES; b++) begin
                        if (c_strb[b]) begin
                            regs[c_addr[IDX_W-1:0]][8*b +: 8] <= c_data[8*b +: 8];
                        end
                    end
                end
            end

            // Sampled before this edge's write lands, so a same-edge write to
            // the same register is not visible to this read.
            if (arready && bus.ARVALID) begin
                rdata_q <= ar_legal ? regs[bus.ARADDR[IDX_W-1:0]] : '0;
                rresp_q <= ar_legal ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign bus.AWREADY = awready;
    assign bus.WREADY  = wready;
    assign bus.BVALID  = bvalid;
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = arready;
    assign bus.RVALID  = rvalid;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign ready       = ready_q;
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
module tb_axi_lite_regfile_slave;
    logic ACLK;
    logic ARESET;
    logic ready;

    axi_lite_regfile_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_regfile_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus),
        .ready  (ready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];

    logic        ready_due = 1'b0;
    logic        b_hold = 1'b0, r_hold = 1'b0;
    logic [1:0]  b_prev, r_prev;
    logic [31:0] rd_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops expected responses on every B/R handshake and checks that
    // held responses stay stable and that ready pulses once per B handshake.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            ready_due = 1'b0;
            b_hold    = 1'b0;
            r_hold    = 1'b0;
        end else begin
            if (ready_due || ready) chk("ready_pulse", 64'(ready), 64'(ready_due));
            ready_due = 1'b0;
            if (b_hold) begin
                chk("b_stable_valid", 64'(bus.BVALID), 64'd1);
                chk("b_stable_resp", 64'(bus.BRESP), 64'(b_prev));
            end
            if (r_hold) begin
                chk("r_stable_valid", 64'(bus.RVALID), 64'd1);
                chk("r_stable_data", 64'({bus.RDATA, bus.RRESP}), 64'({rd_prev, r_prev}));
            end
            b_hold  = bus.BVALID && !bus.BREADY;
            b_prev  = bus.BRESP;
            r_hold  = bus.RVALID && !bus.RREADY;
            r_prev  = bus.RRESP;
            rd_prev = bus.RDATA;
            if (bus.BVALID && bus.BREADY) begin
                if (exp_b.size() == 0) fail_now("b_unexpected");
                else chk("bresp", 64'(bus.BRESP), 64'(exp_b.pop_front()));
                ready_due = 1'b1;
            end
            if (bus.RVALID && bus.RREADY) begin
                if (exp_r.size() == 0) fail_now("r_unexpected");
                else chk("rdata_rresp", 64'({bus.RDATA, bus.RRESP}), 64'(exp_r.pop_front()));
            end
        end
    end

    task automatic wait_drain();
        int i;
        for (i = 0; i < 50 && (exp_b.size() != 0 || exp_r.size() != 0); i++) @(negedge ACLK);
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            fail_now("response_timeout");
            exp_b.delete();
            exp_r.delete();
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
        logic aw_done, w_done, aw_hs, w_hs;
        exp_b.push_back(resp);
        @(posedge ACLK); #1;
        bus.AWADDR = a; bus.AWVALID = 1'b1;
        bus.WDATA = d;  bus.WSTRB = s; bus.WVALID = 1'b1;
        aw_done = 1'b0; w_done = 1'b0;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            @(negedge ACLK);
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            @(posedge ACLK); #1;
            if (aw_hs) begin aw_done = 1'b1; bus.AWVALID = 1'b0; end
            if (w_hs)  begin w_done = 1'b1;  bus.WVALID = 1'b0; end
        end
        if (!(aw_done && w_done)) fail_now("write_handshake_timeout");
        else chk("b_latency", 64'(bus.BVALID), 64'd1);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        wait_drain();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        logic done, hs;
        exp_r.push_back({d, resp});
        @(posedge ACLK); #1;
        bus.ARADDR = a; bus.ARVALID = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge ACLK);
            hs = bus.ARVALID && bus.ARREADY;
            @(posedge ACLK); #1;
            if (hs) begin done = 1'b1; bus.ARVALID = 1'b0; end
        end
        if (!done) fail_now("read_handshake_timeout");
        bus.ARVALID = 1'b0;
        wait_drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b0;
        bus.AWVALID = 0; bus.AWADDR = 0; bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0;
        bus.BREADY = 1; bus.ARVALID = 0; bus.ARADDR = 0; bus.RREADY = 1;

        // 1 reset
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b1;
        @(negedge ACLK);
        chk("rst_awready", 64'(bus.AWREADY), 64'd1);
        chk("rst_wready",  64'(bus.WREADY),  64'd1);
        chk("rst_arready", 64'(bus.ARREADY), 64'd1);
        chk("rst_bvalid",  64'(bus.BVALID),  64'd0);
        chk("rst_rvalid",  64'(bus.RVALID),  64'd0);
        chk("rst_ready",   64'(ready),       64'd0);
        chk("rst_rdata",   64'(bus.RDATA),   64'd0);
        for (int i = 0; i < 8; i++) do_read(32'(i), 32'h0, 2'b00);

        // 2 full write
        do_write(32'd7, 32'h1234_5678, 4'b1111, 2'b00);
        do_read(32'd7, 32'h1234_5678, 2'b00);

        // 3 partial strobes
        do_write(32'd3, 32'h0000_0000, 4'b1111, 2'b00);
        do_write(32'd3, 32'h1234_5678, 4'b1101, 2'b00);
        do_read(32'd3, 32'h1234_0078, 2'b00);
        do_write(32'd1, 32'h1234_5678, 4'b0011, 2'b00);
        do_read(32'd1, 32'h0000_5678, 2'b00);
        do_write(32'd7, 32'hFFFF_FFFF, 4'b0000, 2'b00);
        do_read(32'd7, 32'h1234_5678, 2'b00);

        // 4 split channels: W first, AW next cycle, BREADY low 3 cycles
        exp_b.push_back(2'b00);
        bus.BREADY = 1'b0;
        @(posedge ACLK); #1;
        bus.WDATA = 32'hCAFE_F00D; bus.WSTRB = 4'b1111; bus.WVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.WVALID = 1'b0;
        @(negedge ACLK);
        chk("split_wready_low", 64'(bus.WREADY), 64'd0);
        chk("split_awready_high", 64'(bus.AWREADY), 64'd1);
        chk("split_no_bvalid", 64'(bus.BVALID), 64'd0);
        @(posedge ACLK); #1;
        bus.AWADDR = 32'd4; bus.AWVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0;
        chk("split_bvalid", 64'(bus.BVALID), 64'd1);
        repeat (3) @(posedge ACLK);
        #1 bus.BREADY = 1'b1;
        wait_drain();
        do_read(32'd4, 32'hCAFE_F00D, 2'b00);

        // 5 out of range
        do_write(32'd8, 32'hFFFF_FFFF, 4'b1111, 2'b10);
        do_read(32'd0, 32'h0, 2'b00);
        do_read(32'd8, 32'h0, 2'b10);
        do_write(32'h8000_0001, 32'hFFFF_FFFF, 4'b1111, 2'b10);
        do_read(32'd1, 32'h0000_5678, 2'b00);
        do_read(32'h0000_0107, 32'h0, 2'b10);

        // 6 read and write to the same register on the same edge
        do_write(32'd2, 32'h1111_2222, 4'b1111, 2'b00);
        exp_b.push_back(2'b00);
        exp_r.push_back({32'h1111_2222, 2'b00});
        @(posedge ACLK); #1;
        bus.AWADDR = 32'd2; bus.AWVALID = 1'b1;
        bus.WDATA = 32'hAAAA_5555; bus.WSTRB = 4'b1111; bus.WVALID = 1'b1;
        bus.ARADDR = 32'd2; bus.ARVALID = 1'b1;
        @(negedge ACLK);
        chk("conc_all_ready", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'b111);
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        wait_drain();
        do_read(32'd2, 32'hAAAA_5555, 2'b00);

        // reset while in WR_GOT_AW: transaction dropped, no response
        @(posedge ACLK); #1;
        bus.AWADDR = 32'd5; bus.AWVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0;
        @(negedge ACLK);
        chk("got_aw_awready", 64'(bus.AWREADY), 64'd0);
        chk("got_aw_wready", 64'(bus.WREADY), 64'd1);
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(posedge ACLK); #1 ARESET = 1'b1;
        bus.WDATA = 32'hDEAD_BEEF; bus.WSTRB = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("drop_no_bvalid", 64'(bus.BVALID), 64'd0);
        end
        chk("drop_awready", 64'(bus.AWREADY), 64'd1);
        do_read(32'd5, 32'h0, 2'b00);
        do_read(32'd2, 32'h0, 2'b00);

        repeat (3) @(posedge ACLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
